spi_fpmul_master: RTL and testbench

SPI initiator that gives the system a drop-in `en`/`ready` multiply interface and forwards each request to the remote bfloat16 multiplier over a 4-wire SPI link. On each accepted request it:
- shifts two 16-bit operands out on MOSI;
- waits a fixed turnaround gap;
- shifts the 16-bit product in on MISO and presents it on `y`.

It sits on the host side of the SPI link, opposite the SPI-wrapped `fpmul` responder.

---
 rtl/spi_fpmul_master_if.sv | 12 +
 rtl/spi_fpmul_master.sv | 125 ++++++++++++
 tb/tb_spi_fpmul_master.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_fpmul_master_if.sv
// Request/response bundle between the host system and the SPI bfloat16 multiply initiator.
// The master side issues en/x1/x2; the slave side returns y/ready.
interface spi_fpmul_master_if;
    logic        en;
    logic [15:0] x1;
    logic [15:0] x2;
    logic [15:0] y;
    logic        ready;

    modport master (output en, x1, x2, input y, ready);
    modport slave  (input en, x1, x2, output y, ready);
endinterface

// File: rtl/spi_fpmul_master.sv
// SPI mode-0 initiator: shifts two bfloat16 operands to a remote multiplier,
// idles for a turnaround gap, then reads the 16-bit product back.
module spi_fpmul_master #(
    parameter int CLK_DIV = 2,
    parameter int GAP_CYC = 4
) (
    input  logic                clk,
    input  logic                rst,
    spi_fpmul_master_if.slave   bus,
    output logic                sclk,
    output logic                cs_n,
    output logic                mosi,
    input  logic                miso
);

    localparam int DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam int GAP_W = (GAP_CYC < 2) ? 1 : $clog2(GAP_CYC);

    typedef enum logic [2:0] {
        IDLE,
        TX,
        GAP,
        RX,
        DONE
    } state_t;

    state_t             state;
    logic [31:0]        tx_sh;
    logic [15:0]        rx_sh;
    logic [DIV_W-1:0]   div_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [4:0]         bit_cnt;
    logic               half_done;

    assign half_done = (div_cnt == DIV_W'(CLK_DIV - 1));

    // The outgoing bit is always the MSB of the shift register; shifting in
    // zeros leaves mosi low once all 32 bits are out, through GAP and RX.
    assign mosi = tx_sh[31];

    // NOTE: all state here is updated with non-blocking assignments so every
    // branch reads the pre-edge value of sclk, counters and shift registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tx_sh     <= '0;
            rx_sh     <= '0;
            div_cnt   <= '0;
            gap_cnt   <= '0;
            bit_cnt   <= '0;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            bus.ready <= 1'b0;
            bus.y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        tx_sh     <= {bus.x1, bus.x2};
                        cs_n      <= 1'b0;
                        bus.ready <= 1'b0;
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        state     <= TX;
                    end
                end

                TX: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        if (sclk) begin
                            tx_sh <= {tx_sh[30:0], 1'b0};
                            if (bit_cnt == 5'd31) begin
                                bit_cnt <= '0;
                                gap_cnt <= '0;
                                state   <= (GAP_CYC == 0) ? RX : GAP;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        div_cnt <= '0;
                        state   <= RX;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                RX: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        // Sample on the rising toggle; the responder updates MISO on the fall.
                        if (!sclk) begin
                            rx_sh <= {rx_sh[14:0], miso};
                        end else if (bit_cnt == 5'd15) begin
                            state <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                DONE: begin
                    bus.y     <= rx_sh;
                    bus.ready <= 1'b1;
                    cs_n      <= 1'b1;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_fpmul_master.sv
// Directed bench: two initiators (default timing and CLK_DIV=1/GAP_CYC=0),
// each facing a bfloat16-multiplying SPI responder model.
module tb_spi_fpmul_master;

    logic clk = 1'b0;
    logic rst;

    logic [1:0]        en;
    logic [1:0][15:0]  x1;
    logic [1:0][15:0]  x2;
    logic [1:0][15:0]  y_w;
    logic [1:0]        ready_w;
    logic [1:0]        sclk_w;
    logic [1:0]        cs_w;
    logic [1:0]        mosi_w;
    logic [1:0]        miso_w;
    logic [1:0][31:0]  rises_w;
    logic [1:0][31:0]  last_rises_w;
    logic [1:0][31:0]  frames_w;
    logic [1:0][31:0]  last_cmd_w;

    logic        force_resp;
    logic [15:0] force_val;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Truncating bfloat16 multiply for normal operands; zero handled explicitly.
    function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        logic [15:0] p;
        int          e;
        s = a[15] ^ b[15];
        if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {s, 15'd0};
        p = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
        e = int'(a[14:7]) + int'(b[14:7]) - 127;
        if (p[15]) begin
            e = e + 1;
            return {s, e[7:0], p[14:8]};
        end
        return {s, e[7:0], p[13:7]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spi_fpmul_master_if bus();

        logic [31:0] cmd        = '0;
        logic [31:0] last_cmd   = '0;
        logic [15:0] resp       = '0;
        logic        so         = 1'b0;
        int          n_rise     = 0;
        int          last_rises = 0;
        int          frames     = 0;

        assign bus.en  = en[g];
        assign bus.x1  = x1[g];
        assign bus.x2  = x2[g];
        assign y_w[g]      = bus.y;
        assign ready_w[g]  = bus.ready;
        assign miso_w[g]   = so;
        assign rises_w[g]      = 32'(n_rise);
        assign last_rises_w[g] = 32'(last_rises);
        assign frames_w[g]     = 32'(frames);
        assign last_cmd_w[g]   = last_cmd;

        spi_fpmul_master #(
            .CLK_DIV (g == 0 ? 2 : 1),
            .GAP_CYC (g == 0 ? 4 : 0)
        ) dut (
            .clk  (clk),
            .rst  (rst),
            .bus  (bus),
            .sclk (sclk_w[g]),
            .cs_n (cs_w[g]),
            .mosi (mosi_w[g]),
            .miso (miso_w[g])
        );

        // Responder: capture 32 command bits on SCLK rises, then answer 16 bits.
        always @(posedge sclk_w[g] or posedge cs_w[g]) begin
            if (cs_w[g]) begin
                frames     = frames + 1;
                last_rises = n_rise;
                last_cmd   = cmd;
                n_rise     = 0;
            end else begin
                if (n_rise < 32) cmd = {cmd[30:0], mosi_w[g]};
                n_rise = n_rise + 1;
                if (n_rise == 32)
                    resp = force_resp ? force_val : bf16_mul(cmd[31:16], cmd[15:0]);
            end
        end

        always @(negedge sclk_w[g]) begin
            if (!cs_w[g] && n_rise >= 32 && n_rise < 48) so = resp[47 - n_rise];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start(input int i, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        en[i] = 1'b1;
        x1[i] = a;
        x2[i] = b;
        @(posedge clk);
        #1;
        en[i] = 1'b0;
    endtask

    // Counts cycles from the accepting edge until ready; optionally pulses en mid-frame.
    task automatic wait_ready(input int i, input int busy_at, output int lat, output int cs_hi);
        lat   = 0;
        cs_hi = 0;
        while (ready_w[i] !== 1'b1 && lat < 3000) begin
            @(posedge clk);
            #1;
            lat++;
            if (cs_w[i] && !ready_w[i]) cs_hi++;
            if (busy_at > 0) begin
                if (lat == busy_at) begin
                    en[i] = 1'b1;
                    x1[i] = 16'h3F80;
                end else if (lat == busy_at + 1) begin
                    en[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic run(input int i, input logic [15:0] a, input logic [15:0] b,
                       input int exp_lat, input logic [15:0] exp_y, input int busy_at,
                       input string tag);
        int          lat;
        int          cs_hi;
        logic [31:0] f0;
        f0 = frames_w[i];
        start(i, a, b);
        wait_ready(i, busy_at, lat, cs_hi);
        check({tag, " done"}, 32'(ready_w[i]), 32'd1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " y"}, y_w[i], exp_y);
        check({tag, " mosi stream"}, last_cmd_w[i], {a, b});
        check({tag, " sclk rises"}, last_rises_w[i], 32'd48);
        check({tag, " cs_n low"}, cs_hi, 0);
        check({tag, " cs_n/sclk at end"}, {cs_w[i], sclk_w[i]}, 32'b10);
        repeat (10) @(posedge clk);
        #1;
        check({tag, " frames"}, frames_w[i] - f0, 32'd1);
    endtask

    initial begin
        int lat;
        int cs_hi;
        int k;
        rst        = 1'b1;
        en         = '0;
        x1         = '0;
        x2         = '0;
        force_resp = 1'b0;
        force_val  = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset cs_n", 32'(cs_w[0]), 32'd1);
        check("reset sclk", 32'(sclk_w[0]), 32'd0);
        check("reset mosi", 32'(mosi_w[0]), 32'd0);
        check("reset ready", 32'(ready_w[0]), 32'd0);
        check("reset y", y_w[0], 32'h0000);
        @(negedge clk) rst = 1'b1;

        run(0, 16'h4040, 16'h4000, 197, 16'h40C0, 0, "mul 3x2");
        run(0, 16'hC000, 16'h4000, 197, 16'hC080, 0, "mul neg");
        run(0, 16'h0000, 16'h4000, 197, 16'h0000, 0, "mul zero");
        run(0, 16'h4420, 16'h4200, 197, 16'h46A0, 0, "mul large");

        force_resp = 1'b1;
        force_val  = 16'hA5C3;
        run(1, 16'h4040, 16'h4000, 97, 16'hA5C3, 0, "bit order");
        force_resp = 1'b0;

        run(0, 16'h4040, 16'h4000, 197, 16'h40C0, 50, "busy en");

        // Abort during RX bit 5 (sixth read bit) and check the async reset values.
        start(0, 16'h4420, 16'h4200);
        k = 0;
        while (rises_w[0] < 32'd38 && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("abort reached rx", 32'(rises_w[0] >= 32'd38), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort cs_n", 32'(cs_w[0]), 32'd1);
        check("abort sclk", 32'(sclk_w[0]), 32'd0);
        check("abort mosi", 32'(mosi_w[0]), 32'd0);
        check("abort ready", 32'(ready_w[0]), 32'd0);
        check("abort y", y_w[0], 32'h0000);
        repeat (5) @(posedge clk);
        #1;
        check("abort no ready", 32'(ready_w[0]), 32'd0);
        @(negedge clk) rst = 1'b1;
        run(0, 16'hC000, 16'h4000, 197, 16'hC080, 0, "after abort");

        // en held high: two frames back to back, one idle cycle between them.
        @(negedge clk);
        en[0] = 1'b1;
        x1[0] = 16'h4040;
        x2[0] = 16'h4000;
        @(posedge clk);
        #1;
        x1[0] = 16'hC000;
        wait_ready(0, 0, lat, cs_hi);
        check("hold first latency", lat, 197);
        check("hold first y", y_w[0], 32'h40C0);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (cs_w[0] && k < 10);
        check("hold cs_n gap", k, 1);
        check("hold ready drop", 32'(ready_w[0]), 32'd0);
        wait_ready(0, 0, lat, cs_hi);
        en[0] = 1'b0;
        check("hold second latency", lat, 197);
        check("hold second y", y_w[0], 32'hC080);
        check("hold second cs_n low", cs_hi, 0);
        repeat (10) @(posedge clk);
        #1;
        check("hold stopped", {cs_w[0], ready_w[0]}, 32'b11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
